// File: rtl/fir_sym_folded.sv
// Time-multiplexed symmetric FIR: LANES pre-add/MAC slices fold NC coefficient pairs over FOLD cycles,
// then a lane sum, round-half-up, saturate. Coefficients are runtime-writable while idle.
module fir_sym_folded #(
  parameter int DW    = 10,
  parameter int CW    = 16,
  parameter int OW    = 11,
  parameter int TAPS  = 96,
  parameter int LANES = 6,
  parameter int SHIFT = 16
) (
  input  logic                                         clk,
  input  logic                                         sclr,
  input  logic                                         in_valid,
  input  logic [DW-1:0]                                in_data,
  output logic                                         in_ready,
  output logic                                         out_valid,
  output logic [OW-1:0]                                out_data,
  input  logic                                         coef_we,
  input  logic [((TAPS/2 > 1) ? $clog2(TAPS/2) : 1)-1:0] coef_addr,
  input  logic [CW-1:0]                                coef_wdata,
  output logic                                         coef_err,
  output logic                                         busy
);

  localparam int FOLD = TAPS / (2 * LANES);
  localparam int NC   = TAPS / 2;
  localparam int ACC  = DW + 1 + CW + $clog2(NC);
  localparam int PW   = DW + 1 + CW;
  localparam int KW   = (FOLD > 1) ? $clog2(FOLD) : 1;
  localparam int WW   = ((ACC + 1 > OW) ? ACC + 1 : OW) + 1;

  localparam logic signed [WW-1:0] RND  = (SHIFT > 0) ? (WW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [WW-1:0] OMAX = {{(WW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [WW-1:0] OMIN = {{(WW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  if ((TAPS < 2) || ((TAPS % (2 * LANES)) != 0)) begin : g_bad_taps
    $error("fir_sym_folded: TAPS must be a nonzero multiple of 2*LANES");
  end

  typedef enum logic [1:0] {IDLE, MAC, SUM, OUT} state_t;

  state_t                 state, state_nxt;
  logic signed [DW-1:0]   x    [TAPS];
  logic signed [CW-1:0]   h    [NC];
  logic signed [ACC-1:0]  acc  [LANES];
  logic signed [PW-1:0]   prod [LANES];
  logic signed [ACC-1:0]  sum_q, sum_c;
  logic signed [WW-1:0]   rnd_c, shf_c;
  logic signed [OW-1:0]   sat_c;
  logic [KW-1:0]          k;
  logic                   accept, addr_ok;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign addr_ok  = 32'(coef_addr) < NC;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (k == KW'(FOLD - 1)) state_nxt = SUM;
      SUM:     state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lane l covers coefficient pairs l*FOLD .. l*FOLD+FOLD-1, one per MAC cycle.
  always_comb begin
    int unsigned          j;
    logic signed [DW:0]   pre;
    j   = 0;
    pre = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      j       = l * FOLD + 32'(k);
      pre     = (DW+1)'(x[j]) + (DW+1)'(x[TAPS-1-j]);
      prod[l] = PW'(pre) * PW'(h[j]);
    end
  end

  always_comb begin
    sum_c = '0;
    for (int unsigned l = 0; l < LANES; l++) sum_c = sum_c + acc[l];
    rnd_c = WW'(sum_q) + RND;
    shf_c = rnd_c >>> SHIFT;
    if (shf_c > OMAX)      sat_c = OMAX[OW-1:0];
    else if (shf_c < OMIN) sat_c = OMIN[OW-1:0];
    else                   sat_c = shf_c[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= IDLE;
      k         <= '0;
      x         <= '{default: '0};
      h         <= '{default: '0};
      acc       <= '{default: '0};
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      coef_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= 1'b0;
      coef_err  <= coef_we && (busy || !addr_ok);
      // A write on the accept edge lands before the first MAC cycle reads h.
      if (coef_we && !busy && addr_ok) h[coef_addr] <= coef_wdata;
      case (state)
        IDLE: if (accept) begin
          x[0] <= in_data;
          for (int unsigned i = 1; i < TAPS; i++) x[i] <= x[i-1];
          k   <= '0;
          acc <= '{default: '0};
        end
        MAC: begin
          for (int unsigned l = 0; l < LANES; l++) acc[l] <= acc[l] + ACC'(prod[l]);
          k <= k + KW'(1);
        end
        SUM: sum_q <= sum_c;
        OUT: begin
          out_data  <= sat_c;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sym_folded.sv
// Bench for fir_sym_folded: a SHIFT=0/OW=32 instance and a default instance share all inputs,
// both checked every cycle against a sample-level FIR model plus hand-computed literals.
`timescale 1ns/1ps
module tb_fir_sym_folded;
  localparam int DW = 10, CW = 16, TAPS = 96, NC = 48, AW = 6, LAT = 10;

  logic clk = 1'b0;
  logic sclr = 1'b1, in_valid = 1'b0, coef_we = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic in_ready0, out_valid0, coef_err0, busy0;
  logic in_ready1, out_valid1, coef_err1, busy1;
  logic [31:0] out_data0;
  logic [10:0] out_data1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  fir_sym_folded #(.OW(32), .SHIFT(0)) u_dut0 (
    .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err0), .busy(busy0));

  fir_sym_folded u_dut1 (
    .clk(clk), .sclr(sclr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .coef_err(coef_err1), .busy(busy1));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint rnd_sat(longint v, int sh, int ow);
    longint r  = v;
    longint hi = (longint'(1) <<< (ow - 1)) - 1;
    longint lo = -(longint'(1) <<< (ow - 1));
    if (sh > 0) r = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  // Sample-level model: direct FIR sum over the full tap history on each accepted sample,
  // result due LAT edges later; plus the idle/busy window implied by that latency.
  initial begin : model
    logic s_sclr, s_v, s_we;
    logic signed [DW-1:0] s_d;
    logic [AW-1:0] s_a;
    logic signed [CW-1:0] s_w;
    longint hist [TAPS];
    longint mh [NC];
    longint pend0 = 0, pend1 = 0, eo0 = 0, eo1 = 0, s = 0;
    int cnt = 0;
    bit eov = 0, eerr = 0, en = 0;
    forever begin
      @(posedge clk);
      s_sclr = sclr; s_v = in_valid; s_d = in_data; s_we = coef_we; s_a = coef_addr; s_w = coef_wdata;
      #1;
      if (s_sclr) begin
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        for (int i = 0; i < NC; i++) mh[i] = 0;
        cnt = 0; eov = 0; eerr = 0; eo0 = 0; eo1 = 0; en = 1;
      end else begin
        eerr = s_we && (cnt != 0 || s_a >= NC);
        if (s_we && cnt == 0 && s_a < NC) mh[s_a] = s_w;
        eov = 0;
        if (cnt != 0) begin
          if (cnt == 1) begin eov = 1; eo0 = pend0; eo1 = pend1; end
          cnt--;
        end else if (s_v) begin
          for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
          hist[0] = s_d;
          s = 0;
          for (int i = 0; i < NC; i++) s += (hist[i] + hist[TAPS-1-i]) * mh[i];
          pend0 = rnd_sat(s, 0, 32);
          pend1 = rnd_sat(s, 16, 11);
          cnt = LAT;
        end
      end
      if (en) begin
        check("in_ready0", in_ready0, cnt == 0);
        check("in_ready1", in_ready1, cnt == 0);
        check("busy0", busy0, cnt != 0);
        check("busy1", busy1, cnt != 0);
        check("out_valid0", out_valid0, eov);
        check("out_valid1", out_valid1, eov);
        check("out_data0", $signed(out_data0), eo0);
        check("out_data1", $signed(out_data1), eo1);
        check("coef_err0", coef_err0, eerr);
        check("coef_err1", coef_err1, eerr);
      end
    end
  end

  task automatic do_reset(input int n);
    sclr = 1; in_valid = 0; coef_we = 0;
    repeat (n) @(negedge clk);
    sclr = 0;
  endtask

  task automatic load_coef(input int a, input logic [CW-1:0] v);
    coef_we = 1; coef_addr = AW'(a); coef_wdata = v;
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready1 && n < 40) begin @(negedge clk); n++; end
    if (!in_ready1) check("ready_timeout", in_ready1, 1);
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid1 && n < 20) begin @(negedge clk); n++; end
    check("out_timeout", out_valid1, 1);
  endtask

  task automatic run_sample(input logic [DW-1:0] d, input bit we, input int wa, input logic [CW-1:0] wv,
                            output longint r0, output longint r1);
    wait_ready();
    in_valid = 1; in_data = d;
    if (we) begin coef_we = 1; coef_addr = AW'(wa); coef_wdata = wv; end
    @(negedge clk);
    in_valid = 0; coef_we = 0;
    wait_out();
    r0 = longint'($signed(out_data0));
    r1 = longint'($signed(out_data1));
  endtask

  task automatic impulse_test(input string tag, input bit lit);
    longint r0, r1;
    for (int n = 0; n < 97; n++) begin
      run_sample(DW'(n == 0), 0, 0, '0, r0, r1);
      if (lit) check(tag, r0, (n < 48) ? n + 1 : ((n < 96) ? 96 - n : 0));
      else     check(tag, r0, 0);
    end
  endtask

  initial begin : stim
    longint r0, r1;
    int acc_t[$], out_t[$], nov;
    @(negedge clk);
    do_reset(2);
    check("reset_ready", in_ready1, 1);
    check("reset_out", $signed(out_data1), 0);

    // Impulse response, h[i] = i+1
    for (int i = 0; i < NC; i++) load_coef(i, CW'(i + 1));
    impulse_test("impulse", 1);

    // Handshake cadence with in_valid held high
    do_reset(1);
    in_valid = 1; in_data = DW'($urandom);
    for (int c = 0; c < 60; c++) begin
      if (in_ready1) acc_t.push_back(c);
      @(negedge clk);
      if (out_valid1) out_t.push_back(c);
      if (acc_t.size() > 0 && acc_t[$] == c) in_data = DW'($urandom);
    end
    in_valid = 0;
    check("accept_count", acc_t.size(), 6);
    check("out_count", out_t.size(), 5);
    for (int i = 1; i < acc_t.size(); i++) check("accept_gap", acc_t[i] - acc_t[i-1], 11);
    for (int i = 0; i < out_t.size(); i++) check("latency", out_t[i] - acc_t[i], LAT);
    repeat (12) @(negedge clk);

    // Saturation
    do_reset(1);
    for (int i = 0; i < NC; i++) load_coef(i, 16'h7FFF);
    for (int n = 0; n < 96; n++) run_sample(10'sd511, 0, 0, '0, r0, r1);
    check("sat_pos1", r1, 1023);
    check("sat_pos0", r0, 64'sd48 * 1022 * 32767);
    for (int n = 0; n < 96; n++) run_sample(-10'sd512, 0, 0, '0, r0, r1);
    check("sat_neg1", r1, -1024);
    check("sat_neg0", r0, -64'sd48 * 1024 * 32767);

    // Rounding with h[0] = 0x4000
    do_reset(1);
    load_coef(0, 16'h4000);
    run_sample(10'sd2, 0, 0, '0, r0, r1);  check("round_p2", r1, 1);  check("round_p2_raw", r0, 32768);
    run_sample(10'sd1, 0, 0, '0, r0, r1);  check("round_p1", r1, 0);
    run_sample(-10'sd2, 0, 0, '0, r0, r1); check("round_m2", r1, 0);
    run_sample(-10'sd3, 0, 0, '0, r0, r1); check("round_m3", r1, -1); check("round_m3_raw", r0, -49152);

    // Coefficient write during MAC is dropped
    wait_ready();
    in_valid = 1; in_data = '0;
    @(negedge clk);
    in_valid = 0; coef_we = 1; coef_addr = '0; coef_wdata = 16'h7000;
    @(negedge clk);
    coef_we = 0;
    check("coef_err_pulse", coef_err1, 1);
    wait_out();
    run_sample(10'sd1, 0, 0, '0, r0, r1);
    check("old_coef", r0, 16384);
    // Write on the handshake edge is used by that sample
    run_sample(10'sd8, 1, 0, 16'h2000, r0, r1);
    check("same_edge_raw", r0, 65536);
    check("same_edge", r1, 1);

    // Reset during MAC, k=3
    wait_ready();
    in_valid = 1; in_data = 10'sd5;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    sclr = 1;
    @(negedge clk);
    sclr = 0;
    check("ready_after_reset", in_ready1, 1);
    nov = 0;
    for (int c = 0; c < 15; c++) begin @(negedge clk); if (out_valid1) nov++; end
    check("aborted_no_out", nov, 0);
    impulse_test("cleared_coef", 0);
    do_reset(1);
    for (int i = 0; i < NC; i++) load_coef(i, CW'(i + 1));
    impulse_test("impulse_reload", 1);

    // Random traffic, writes at any time, occasional reset
    do_reset(1);
    for (int c = 0; c < 800; c++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_data    = DW'($urandom);
      coef_we    = ($urandom_range(0, 5) == 0);
      coef_addr  = AW'($urandom);
      coef_wdata = CW'($urandom);
      sclr       = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    sclr = 0; in_valid = 0; coef_we = 0;
    repeat (15) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sym_folded.md
Name: fir_sym_folded

Overview:
- Parametrised, time-multiplexed symmetric FIR filter. It is the successor to the fixed 96-tap / 6-lane filter.
- TAPS, LANES, data, coefficient and output widths are all parameters.
- Adds a valid/ready sample handshake, runtime-writable coefficients, and rounding with saturation on the output.
- Sits between the ADC sample stream and downstream decimation/processing. Each lane maps to one pre-adder/multiplier/accumulator slice.

Parameters:
- DW, 10, signed input sample width
- CW, 16, signed coefficient width
- OW, 11, signed output width
- TAPS, 96, total filter length; must be even and divisible by 2*LANES (otherwise elaboration error)
- LANES, 6, parallel MAC lanes
- SHIFT, 16, output right-shift, 0..ACC-1
- Derived: FOLD = TAPS/(2*LANES) (8 by default); NC = TAPS/2; ACC = DW+1+CW+clog2(NC)

Ports:
- clk  in  1  single clock, rising edge
- sclr  in  1  synchronous active-high reset
- in_valid  in  1  sample offered
- in_data  in  DW  signed sample
- in_ready  out  1  high only in IDLE
- out_valid  out  1  one-cycle pulse per accepted sample
- out_data  out  OW  signed filtered result, held until the next out_valid
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(NC)  coefficient index (h[i] = h[TAPS-1-i])
- coef_wdata  in  CW  signed coefficient
- coef_err  out  1  one-cycle pulse when a write is dropped
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sclr=1 at a clk edge):
  - state=IDLE; out_valid=0, out_data=0, coef_err=0, busy=0; in_ready=1 from the first cycle after reset.
  - Delay line, accumulators and all NC coefficients cleared to 0.
  - Reset mid-operation aborts the sample: no out_valid for it.
- Handshake: a sample is accepted at an edge where in_valid & in_ready.
  - The sample shifts into x[0]; x[i] moves to x[i+1]; x[TAPS-1] is discarded.
  - in_valid while not ready is ignored. The source holds the sample, nothing is buffered.
- FSM:
  - IDLE: on handshake go to MAC, k=0, accumulators cleared.
  - MAC: FOLD cycles, k=0..FOLD-1. Lane l adds (x[j]+x[TAPS-1-j])*h[j], with j = l*FOLD+k. After k=FOLD-1 go to SUM.
  - SUM: one cycle; adds the LANES accumulators at full ACC precision, no wrap. Go to OUT.
  - OUT: out_data registered; out_valid=1 for exactly one cycle; in_ready=0. Go to IDLE.
- Latency: out_valid asserts FOLD+2 cycles after the handshake edge. Maximum throughput is one sample per FOLD+3 cycles (11 by default).
- Arithmetic:
  - Pre-add is DW+1 bits signed; product is DW+1+CW bits.
  - Output = (sum + 2^(SHIFT-1)) >>> SHIFT, i.e. round half toward +inf. No rounding constant is added when SHIFT=0.
  - Result saturates to [-2^(OW-1), 2^(OW-1)-1].
- Coefficient writes:
  - Accepted only in IDLE.
  - A write on the same edge as a sample handshake takes effect before that sample's MAC phase, so the new value is used.
  - coef_we while busy: the write is dropped, coef_err pulses the next cycle, coefficients are unchanged.
- Simultaneous sclr and any input: reset wins.

Test Plan:
1. Impulse response, SHIFT=0, OW=32.
   - Stimulus: load h[i]=i+1 (i=0..47); feed 1, then zeros.
   - Required: 96 outputs 1,2,…,48,48,…,2,1, then 0.
2. Handshake and latency, default parameters.
   - Stimulus: in_valid held high.
   - Required: in_ready high one cycle in every 11; out_valid exactly 10 cycles after each accept; busy low only in IDLE.
3. Saturation.
   - Stimulus: all h=0x7FFF, in_data=+511 for 96 samples.
   - Required: out_data=0x3FF (1023).
   - Stimulus: in_data=-512 for 96 samples.
   - Required: out_data=-1024.
4. Rounding, SHIFT=16.
   - Setup: h[0]=0x4000, others 0, single sample into an empty line.
   - in_data=2 → 1; in_data=1 → 0; in_data=-2 → 0; in_data=-3 → -1.
5. Coefficient write while busy.
   - Stimulus: coef_we during MAC.
   - Required: coef_err pulse; the following impulse test shows the old coefficient.
   - Stimulus: write in the same cycle as a handshake.
   - Required: the new value is used for that sample.
6. Reset mid-MAC (k=3).
   - Required: no out_valid for the aborted sample; in_ready=1 the cycle after reset.
   - A subsequent impulse gives all zeros (coefficients cleared). After reloading coefficients, the impulse response is clean with no stale delay-line data.
